// File: rtl/uart_io_pkg.sv
// Shared types and widths for the UART I/O controller.
package uart_io_pkg;

  localparam int BYTE_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_WAIT = 1'b1
  } rd_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_WAIT = 1'b1
  } wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; full/empty come from the count before this cycle's pop.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int W          = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [W-1:0]          din,
  input  logic                  pop,
  output logic [W-1:0]          dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [W-1:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic                    push_ok;
  logic                    pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  // A push into a full FIFO is refused even when a pop frees a slot this cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_io_ctrl.sv
// Buffers exec UART read/write requests through RX/TX FIFOs and returns one-cycle done pulses.
// Optional word reads (4 bytes, big-endian) are enabled by defining UART_IO_WORD_EN.
module uart_io_ctrl
  import uart_io_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_renable,
`ifdef UART_IO_WORD_EN
  input  logic              uart_rword,
`endif
  output logic              uart_rdone,
  output logic [DATA_W-1:0] uart_rd,
  input  logic              uart_wenable,
  input  logic [DATA_W-1:0] uart_wd,
  output logic              uart_wdone,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              rx_overflow
);

  localparam int PAD_W = DATA_W - BYTE_W;

  logic              word_req;
`ifdef UART_IO_WORD_EN
  assign word_req = uart_rword;
`else
  assign word_req = 1'b0;
`endif

  logic [BYTE_W-1:0]       rx_dout;
  logic [RX_DEPTH_LOG2:0]  rx_count_unused;
  logic                    rx_full;
  logic                    rx_empty;
  logic                    rx_pop;

  logic [TX_DEPTH_LOG2:0]  tx_count_unused;
  logic                    tx_full;
  logic                    tx_empty;
  logic                    tx_push;
  logic [BYTE_W-1:0]       tx_din;

  logic                    wd_high_unused;
  assign wd_high_unused = ^uart_wd[DATA_W-1:BYTE_W];

  sync_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2), .W(BYTE_W)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .count (rx_count_unused),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2), .W(BYTE_W)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .din   (tx_din),
    .pop   (tx_valid && tx_ready),
    .dout  (tx_data),
    .count (tx_count_unused),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_valid = !tx_empty;

  always_ff @(posedge clk) begin
    if (!rstn)                    rx_overflow <= 1'b0;
    else if (rx_valid && rx_full) rx_overflow <= 1'b1;
  end

  // Read FSM: acc shifts in every popped byte so a word read ends with the first byte on top.
  rd_state_t         rd_state, rd_state_n;
  logic              word_mode, word_mode_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic              rdone_n;
  logic [DATA_W-1:0] rd_n;

  always_comb begin
    rd_state_n  = rd_state;
    word_mode_n = word_mode;
    byte_cnt_n  = byte_cnt;
    acc_n       = acc;
    rdone_n     = 1'b0;
    rd_n        = uart_rd;
    rx_pop      = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (uart_renable) begin
          word_mode_n = word_req;
          byte_cnt_n  = 2'd0;
          if (!rx_empty) begin
            rx_pop = 1'b1;
            acc_n  = {acc[PAD_W-1:0], rx_dout};
            if (word_req) begin
              rd_state_n = R_WAIT;
              byte_cnt_n = 2'd1;
            end else begin
              rdone_n = 1'b1;
              rd_n    = {{PAD_W{1'b0}}, rx_dout};
            end
          end else begin
            rd_state_n = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (!rx_empty) begin
          rx_pop = 1'b1;
          acc_n  = {acc[PAD_W-1:0], rx_dout};
          if (!word_mode || byte_cnt == 2'd3) begin
            rdone_n    = 1'b1;
            rd_n       = word_mode ? {acc[PAD_W-1:0], rx_dout} : {{PAD_W{1'b0}}, rx_dout};
            rd_state_n = R_IDLE;
          end else begin
            byte_cnt_n = byte_cnt + 2'd1;
          end
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_state   <= R_IDLE;
      word_mode  <= 1'b0;
      byte_cnt   <= 2'd0;
      acc        <= '0;
      uart_rdone <= 1'b0;
      uart_rd    <= '0;
    end else begin
      rd_state   <= rd_state_n;
      word_mode  <= word_mode_n;
      byte_cnt   <= byte_cnt_n;
      acc        <= acc_n;
      uart_rdone <= rdone_n;
      uart_rd    <= rd_n;
    end
  end

  // Write FSM: in W_IDLE the byte goes straight from uart_wd, in W_WAIT from the latch.
  wr_state_t         wr_state, wr_state_n;
  logic [BYTE_W-1:0] wbyte, wbyte_n;
  logic              wdone_n;

  assign tx_din = (wr_state == W_IDLE) ? uart_wd[BYTE_W-1:0] : wbyte;

  always_comb begin
    wr_state_n = wr_state;
    wbyte_n    = wbyte;
    wdone_n    = 1'b0;
    tx_push    = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (uart_wenable) begin
          wbyte_n = uart_wd[BYTE_W-1:0];
          if (!tx_full) begin
            tx_push = 1'b1;
            wdone_n = 1'b1;
          end else begin
            wr_state_n = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (!tx_full) begin
          tx_push    = 1'b1;
          wdone_n    = 1'b1;
          wr_state_n = W_IDLE;
        end
      end
      default: wr_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_state   <= W_IDLE;
      wbyte      <= '0;
      uart_wdone <= 1'b0;
    end else begin
      wr_state   <= wr_state_n;
      wbyte      <= wbyte_n;
      uart_wdone <= wdone_n;
    end
  end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl: RX reads, TX writes with backpressure, overflow, reset, word reads.
module tb_uart_io_ctrl;

  logic        clk;
  logic        rstn;
  logic        uart_renable;
  logic        uart_rword;
  logic        uart_rdone;
  logic [31:0] uart_rd;
  logic        uart_wenable;
  logic [31:0] uart_wd;
  logic        uart_wdone;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_overflow;

  int tests  = 0;
  int failed = 0;

  uart_io_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .uart_renable (uart_renable),
`ifdef UART_IO_WORD_EN
    .uart_rword   (uart_rword),
`endif
    .uart_rdone   (uart_rdone),
    .uart_rd      (uart_rd),
    .uart_wenable (uart_wenable),
    .uart_wd      (uart_wd),
    .uart_wdone   (uart_wdone),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_overflow  (rx_overflow)
  );

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    int k;
    int pulses;
    logic [31:0] seen;

    rstn = 1'b0; uart_renable = 1'b0; uart_rword = 1'b0; uart_wenable = 1'b0;
    uart_wd = '0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    tick(); tick();
    check("rst_rdone", {31'd0, uart_rdone}, 32'd0);
    check("rst_rd", uart_rd, 32'd0);
    check("rst_wdone", {31'd0, uart_wdone}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_overflow", {31'd0, rx_overflow}, 32'd0);
    rstn = 1'b1;
    tick();

    // Byte already buffered: rdone the cycle after the request.
    push_rx(8'h41);
    tick(); tick();
    uart_renable = 1'b1; tick(); uart_renable = 1'b0;
    check("rd1_done", {31'd0, uart_rdone}, 32'd1);
    check("rd1_data", uart_rd, 32'h0000_0041);
    tick();
    check("rd1_pulse_len", {31'd0, uart_rdone}, 32'd0);

    // Request on empty FIFO, byte arrives later: rdone two cycles after rx_valid.
    uart_renable = 1'b1; tick(); uart_renable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rd2_wait", {31'd0, uart_rdone}, 32'd0);
      tick();
    end
    push_rx(8'h7F);
    check("rd2_no_bypass", {31'd0, uart_rdone}, 32'd0);
    tick();
    check("rd2_done", {31'd0, uart_rdone}, 32'd1);
    check("rd2_data", uart_rd, 32'h0000_007F);
    tick();
    check("rd2_pulse_len", {31'd0, uart_rdone}, 32'd0);

    // 17 writes into a depth-16 TX FIFO with the PHY stalled.
    tx_ready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      uart_wenable = 1'b1;
      uart_wd = {24'hABCDEF, 8'(i)};
      tick();
      uart_wenable = 1'b0;
      check("wr_fill_wdone", {31'd0, uart_wdone}, (i < 16) ? 32'd1 : 32'd0);
    end
    check("wr_full_valid", {31'd0, tx_valid}, 32'd1);
    check("wr_full_head", {24'd0, tx_data}, 32'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wr_stall_wdone", {31'd0, uart_wdone}, 32'd0);
    end
    tx_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 17; c++) begin
      if (tx_valid) begin
        check("tx_order", {24'd0, tx_data}, k);
        k++;
      end
      if (c == 1) check("wr17_wdone_early", {31'd0, uart_wdone}, 32'd0);
      if (c == 2) check("wr17_wdone", {31'd0, uart_wdone}, 32'd1);
      if (c == 3) check("wr17_wdone_len", {31'd0, uart_wdone}, 32'd0);
      tick();
    end
    check("tx_drain_count", k, 32'd17);
    check("tx_drained", {31'd0, tx_valid}, 32'd0);

    // Overflow: 17th byte dropped, flag sticky, first 16 read back in order.
    for (int i = 0; i < 17; i++) begin
      push_rx(8'h80 + 8'(i));
      check("ovf_flag", {31'd0, rx_overflow}, (i < 16) ? 32'd0 : 32'd1);
    end
    tick(); tick();
    check("ovf_sticky", {31'd0, rx_overflow}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      uart_renable = 1'b1; tick();
      check("ovf_rd_done", {31'd0, uart_rdone}, 32'd1);
      check("ovf_rd_data", uart_rd, {24'd0, 8'h80 + 8'(i)});
    end
    uart_renable = 1'b0;
    tick();
    check("ovf_rd_end", {31'd0, uart_rdone}, 32'd0);
    check("ovf_still_set", {31'd0, rx_overflow}, 32'd1);

    // Reset in the middle of a waiting read with TX bytes queued.
    tx_ready = 1'b0;
    uart_wenable = 1'b1; uart_wd = 32'h0000_00A1; tick();
    uart_wd = 32'h0000_00A2; tick();
    uart_wenable = 1'b0;
    check("pre_rst_tx_valid", {31'd0, tx_valid}, 32'd1);
    uart_renable = 1'b1; tick(); uart_renable = 1'b0;
    tick();
    rstn = 1'b0; tick(); rstn = 1'b1;
    check("rst2_rdone", {31'd0, uart_rdone}, 32'd0);
    check("rst2_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst2_overflow", {31'd0, rx_overflow}, 32'd0);
    tx_ready = 1'b1;
    push_rx(8'h55);
    tick();
    check("rst2_no_stale_read", {31'd0, uart_rdone}, 32'd0);
    check("rst2_tx_empty", {31'd0, tx_valid}, 32'd0);
    uart_renable = 1'b1; tick(); uart_renable = 1'b0;
    check("rst2_rd_done", {31'd0, uart_rdone}, 32'd1);
    check("rst2_rd_data", uart_rd, 32'h0000_0055);
    tick();

`ifdef UART_IO_WORD_EN
    // Word read: four bytes, big-endian, one done pulse.
    uart_renable = 1'b1; uart_rword = 1'b1; tick();
    uart_renable = 1'b0; uart_rword = 1'b0;
    push_rx(8'h12);
    push_rx(8'h34);
    push_rx(8'h56);
    push_rx(8'h78);
    pulses = 0;
    seen = '0;
    for (int c = 0; c < 10; c++) begin
      if (uart_rdone) begin
        pulses++;
        seen = uart_rd;
      end
      tick();
    end
    check("word_pulses", pulses, 32'd1);
    check("word_data", seen, 32'h1234_5678);
`else
    pulses = 0;
    seen = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
